// File: rtl/stopwatch_pkg.sv
// Shared state encoding for the stopwatch control block.
package stopwatch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_e;

  // The counter keeps running while the display is frozen in LAP.
  function automatic logic is_running(input state_e s);
    return (s == ST_RUN) || (s == ST_LAP);
  endfunction

endpackage

// File: rtl/btn_edge_lockout.sv
// Rising-edge press detector with a post-press lockout window for debounce.
module btn_edge_lockout #(
  parameter int LOCKOUT_CYC = 1_000_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn,
  output logic Press
);

  localparam int              LW   = $clog2(LOCKOUT_CYC + 1);
  localparam logic [LW-1:0]   LOAD = LW'(LOCKOUT_CYC);

  logic          btn_q;
  logic [LW-1:0] lockout;

  // Combinational so the FSM can act on the same edge that first samples the press.
  assign Press = Btn & ~btn_q & (lockout == '0);

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      btn_q   <= 1'b0;
      lockout <= '0;
    end else begin
      btn_q <= Btn;
      if (Press) begin
        lockout <= LOAD;
      end else if (lockout != '0) begin
        lockout <= lockout - LW'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button commands, run/lap/pause FSM and count-enable timebase.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int TICK_HZ     = 100,
  parameter int LOCKOUT_CYC = 1_000_000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               BtnSS,
  input  logic               BtnLC,
  output logic               Tick,
  output logic               CountClr,
  output logic               LapHold,
  output logic               Running,
  output logic [STATE_W-1:0] State
);

  localparam int            DIV       = CLK_HZ / TICK_HZ;
  localparam int            PW        = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  state_e        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic          tick_nxt, clr_nxt;
  logic          ss_press, lc_press;

  btn_edge_lockout #(.LOCKOUT_CYC(LOCKOUT_CYC)) u_ss (
    .Clk   (Clk),
    .Reset (Reset),
    .Btn   (BtnSS),
    .Press (ss_press)
  );

  btn_edge_lockout #(.LOCKOUT_CYC(LOCKOUT_CYC)) u_lc (
    .Clk   (Clk),
    .Reset (Reset),
    .Btn   (BtnLC),
    .Press (lc_press)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would infer a latch.
    state_nxt = state;
    clr_nxt   = 1'b0;
    presc_nxt = presc;
    tick_nxt  = 1'b0;

    // Start/Stop wins over Lap/Clear when both arrive in the same cycle.
    unique case (state)
      ST_IDLE: begin
        if (ss_press) begin
          state_nxt = ST_RUN;
        end else if (lc_press) begin
          clr_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (ss_press)      state_nxt = ST_PAUSE;
        else if (lc_press) state_nxt = ST_LAP;
      end
      ST_LAP: begin
        if (ss_press)      state_nxt = ST_PAUSE;
        else if (lc_press) state_nxt = ST_RUN;
      end
      ST_PAUSE: begin
        if (ss_press) begin
          state_nxt = ST_RUN;
        end else if (lc_press) begin
          state_nxt = ST_IDLE;
          clr_nxt   = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Timebase follows the state held during the cycle, so the first tick after
    // leaving IDLE lands exactly DIV edges later and PAUSE keeps the partial count.
    if (state == ST_IDLE) begin
      presc_nxt = '0;
    end else if (is_running(state)) begin
      if (presc == PRESC_MAX) begin
        presc_nxt = '0;
        tick_nxt  = 1'b1;
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      presc    <= '0;
      Tick     <= 1'b0;
      CountClr <= 1'b0;
      LapHold  <= 1'b0;
      Running  <= 1'b0;
    end else begin
      state    <= state_nxt;
      presc    <= presc_nxt;
      Tick     <= tick_nxt;
      CountClr <= clr_nxt;
      LapHold  <= (state_nxt == ST_LAP);
      Running  <= is_running(state_nxt);
    end
  end

  assign State = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench: directed scenarios plus random button traffic against a cycle-count model.
module tb_stopwatch_ctrl;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int LOCK    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss  = 1'b0;
  logic       lc  = 1'b0;
  logic       tick, count_clr, lap_hold, running;
  logic [1:0] state;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .TICK_HZ     (TICK_HZ),
    .LOCKOUT_CYC (LOCK)
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .BtnSS    (ss),
    .BtnLC    (lc),
    .Tick     (tick),
    .CountClr (count_clr),
    .LapHold  (lap_hold),
    .Running  (running),
    .State    (state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: states 0..3 as IDLE/RUN/LAP/PAUSE, transitions from tables,
  // timebase as a count of running cycles since the last return to IDLE.
  int ss_tbl [4] = '{1, 3, 3, 1};
  int lc_tbl [4] = '{0, 2, 1, 0};
  int m_st, m_run, cyc, last_ss, last_lc;
  bit prev_ss, prev_lc, m_tick, m_clr;

  int tick_cnt;
  int st_changes;
  logic [1:0] last_state;

  task automatic model_edge(input bit r, input bit s, input bit l);
    bit sp, lp;
    if (r) begin
      m_st = 0; m_run = 0; prev_ss = 0; prev_lc = 0;
      last_ss = cyc - 100; last_lc = cyc - 100;
      m_tick = 0; m_clr = 0;
    end else begin
      sp = s && !prev_ss && (cyc - last_ss > LOCK);
      lp = l && !prev_lc && (cyc - last_lc > LOCK);
      if (sp) last_ss = cyc;
      if (lp) last_lc = cyc;
      prev_ss = s;
      prev_lc = l;
      m_tick = 0;
      m_clr  = 0;
      if (m_st == 0) begin
        m_run = 0;
      end else if (m_st == 1 || m_st == 2) begin
        m_run++;
        m_tick = (m_run % DIV == 0);
      end
      if (sp) begin
        m_st = ss_tbl[m_st];
      end else if (lp) begin
        m_clr = (m_st == 0 || m_st == 3);
        m_st  = lc_tbl[m_st];
      end
    end
    cyc++;
  endtask

  task automatic step();
    logic [5:0] exp_v;
    @(posedge clk);
    model_edge(rst, ss, lc);
    #1;
    exp_v = {m_st[1:0], m_tick, m_clr, (m_st == 2), (m_st == 1 || m_st == 2)};
    check("cyc", {26'd0, state, tick, count_clr, lap_hold, running}, {26'd0, exp_v});
    if (tick) tick_cnt++;
    if (state !== last_state) st_changes++;
    last_state = state;
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic press_ss();
    ss = 1'b1; step(); ss = 1'b0;
  endtask

  task automatic press_lc();
    lc = 1'b1; step(); lc = 1'b0;
  endtask

  initial begin
    cyc = 0; last_state = 2'd0;

    // 1: reset then idle
    rst = 1'b1;
    cycles(5);
    rst = 1'b0;
    tick_cnt = 0;
    cycles(50);
    check("idle_no_tick", tick_cnt, 0);
    check("idle_state", state, 0);

    // 2: start from IDLE, three ticks in 30 cycles
    press_ss();
    check("start_state", state, 1);
    check("start_running", running, 1);
    tick_cnt = 0;
    cycles(30);
    check("run_ticks", tick_cnt, 3);

    // 3: pause with partial tick, resume
    for (int i = 0; i < DIV && (m_run % DIV) != 6; i++) step();
    check("pause_align", dut.presc, 6);
    press_ss();
    check("pause_state", state, 3);
    tick_cnt = 0;
    cycles(20);
    check("pause_no_tick", tick_cnt, 0);
    press_ss();
    check("resume_state", state, 1);
    cycles(12);

    // 4: lap, a press inside the lockout window, lap release
    press_lc();
    check("lap_hold", lap_hold, 1);
    cycles(2);
    press_lc();
    check("lap_locked_out", state, 2);
    cycles(6);
    press_lc();
    check("lap_release_state", state, 1);
    check("lap_release_hold", lap_hold, 0);
    cycles(6);

    // 5: simultaneous presses in PAUSE, then clear
    press_ss();
    cycles(6);
    ss = 1'b1; lc = 1'b1; step(); ss = 1'b0; lc = 1'b0;
    check("both_state", state, 1);
    check("both_no_clr", count_clr, 0);
    cycles(6);
    press_ss();
    cycles(6);
    press_lc();
    check("clear_pulse", count_clr, 1);
    check("clear_state", state, 0);
    step();
    check("clear_one_cycle", count_clr, 0);

    // 6: held button gives one transition; reset in LAP
    cycles(6);
    st_changes = 0;
    ss = 1'b1;
    cycles(30);
    ss = 1'b0;
    check("hold_one_transition", st_changes, 1);
    cycles(6);
    press_lc();
    check("lap_before_reset", state, 2);
    cycles(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("reset_state", state, 0);
    check("reset_laphold", lap_hold, 0);
    check("reset_presc", dut.presc, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      ss  = ($urandom_range(0, 5) == 0);
      lc  = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; ss = 1'b0; lc = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
